kypd_scan: RTL and testbench



---
 rtl/kypd_pkg.sv | 23 ++
 rtl/scan_tick.sv | 30 +++
 rtl/kypd_scan.sv | 177 +++++++++++++++++
 tb/tb_kypd_scan.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/kypd_pkg.sv
// Shared types and keymap for the keypad scanner.
package kypd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_t;

  // Nibble index is {row, col}; row 0 is the top row 1,2,3,A.
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;

  function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
    return KEYMAP[{r, c, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Enable-pulse divider: one-clk tick every CLK_HZ/TARGET_HZ clocks.
// The ratio must be at least 4 so the row synchronizer settles after a column change.
module scan_tick #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TARGET_HZ = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV = CLK_HZ / TARGET_HZ;
  localparam int W   = (DIV > 2) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  // Down-counter reloaded at terminal count; tick fires while it sits at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= W'(DIV - 1);
    end else begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/kypd_scan.sv
// 4x4 keypad scanner with per-scan debounce and a four-key history.
//
//   state   | meaning
//   --------+------------------------------------------------------
//   IDLE    | no key accepted, waiting for a SINGLE scan
//   CAND    | counting consecutive SINGLE scans of the same key
//   HELD    | key accepted, counting consecutive NONE scans to release
module kypd_scan
  import kypd_pkg::*;
#(
  parameter int CLK_HZ         = 100_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] digits
);

  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] DB = CW'(DEBOUNCE_SCANS);

  logic [3:0]    row_meta, row_sync;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    acc_hits, hits_nx;
  logic [3:0]    acc_code, code_nx, col_code;
  logic [2:0]    col_hits, tot_hits;
  logic          scan_done;
  scan_res_t     scan_res;
  logic [3:0]    scan_code;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, rel, rel_nx;
  logic [3:0]    cand, cand_nx;
  logic          accept;

  scan_tick #(.CLK_HZ(CLK_HZ), .TARGET_HZ(SCAN_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Two-flop synchronizer for the asynchronous row inputs (idle high).
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign col = ~(4'b0001 << col_idx);

  // Merge the current column's pressed rows into the running scan tally (saturates at 2 = multi).
  always_comb begin
    col_hits = '0;
    col_code = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        col_hits = col_hits + 3'd1;
        col_code = key_of(2'(r), col_idx);
      end
    end
    tot_hits = 3'(acc_hits) + col_hits;
    hits_nx  = (tot_hits >= 3'd2) ? 2'd2 : tot_hits[1:0];
    code_nx  = (col_hits != 3'd0) ? col_code : acc_code;
  end

  // Sample on each tick, step the column, and classify after column 3.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_idx   <= 2'd0;
      acc_hits  <= 2'd0;
      acc_code  <= 4'h0;
      scan_done <= 1'b0;
      scan_res  <= RES_NONE;
      scan_code <= 4'h0;
    end else begin
      scan_done <= 1'b0;
      if (tick) begin
        col_idx <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          scan_done <= 1'b1;
          scan_res  <= (hits_nx == 2'd0) ? RES_NONE :
                       (hits_nx == 2'd1) ? RES_SINGLE : RES_MULTI;
          scan_code <= code_nx;
          acc_hits  <= 2'd0;
          acc_code  <= 4'h0;
        end else begin
          acc_hits <= hits_nx;
          acc_code <= code_nx;
        end
      end
    end
  end

  // Debounce FSM next-state; acceptance happens the clk after the count reaches DB.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rel_nx   = rel;
    cand_nx  = cand;
    accept   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (scan_done && scan_res == RES_SINGLE) begin
          cand_nx  = scan_code;
          cnt_nx   = CW'(1);
          state_nx = ST_CAND;
        end
      end
      ST_CAND: begin
        if (cnt == DB) begin
          accept   = 1'b1;
          cnt_nx   = '0;
          rel_nx   = '0;
          state_nx = ST_HELD;
        end else if (scan_done) begin
          if (scan_res == RES_SINGLE && scan_code == cand) begin
            cnt_nx = cnt + CW'(1);
          end else begin
            cnt_nx   = '0;
            state_nx = ST_IDLE;
          end
        end
      end
      ST_HELD: begin
        if (scan_done) begin
          if (scan_res == RES_NONE) begin
            if (rel == DB - CW'(1)) begin
              rel_nx   = '0;
              state_nx = ST_IDLE;
            end else begin
              rel_nx = rel + CW'(1);
            end
          end else begin
            rel_nx = '0;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM registers and the accepted-key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rel       <= '0;
      cand      <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      digits    <= 16'h0000;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      rel       <= rel_nx;
      cand      <= cand_nx;
      key_valid <= accept;
      if (accept) begin
        key_code <= cand;
        digits   <= {digits[11:0], cand};
      end
    end
  end

  assign key_held = (state == ST_HELD);

endmodule

// File: tb/tb_kypd_scan.sv
// Directed plus random keypad stimulus against a scan-level reference model.
module tb_kypd_scan;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] digits;

  logic [15:0] pressed = '0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model state, advanced once per full scan.
  int          m_pulses = 0;
  int          m_run    = 0;
  int          m_rel    = 0;
  bit          m_held   = 1'b0;
  logic [3:0]  m_cand   = 4'h0;
  logic [3:0]  m_code   = 4'h0;
  logic [15:0] m_digits = 16'h0000;

  // Keypad legend indexed row*4+col.
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'h0, 4'hF, 4'hE, 4'hD};

  kypd_scan #(.CLK_HZ(1000), .SCAN_HZ(250), .DEBOUNCE_SCANS(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digits    (digits)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(negedge clk) if (key_valid) pulses++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    check("pulses",   16'(pulses), 16'(m_pulses));
    check("key_held", {15'd0, key_held}, {15'd0, m_held});
    check("key_code", {12'd0, key_code}, {12'd0, m_code});
    check("digits",   digits, m_digits);
  endtask

  // Apply the debounce rules to one full scan with the given set of pressed keys.
  task automatic model_scan(input logic [15:0] m);
    int n = 0;
    logic [3:0] code = 4'h0;
    for (int i = 0; i < 16; i++) if (m[i]) begin n++; code = keymap[i]; end
    if (!m_held) begin
      if (n == 1 && m_run > 0 && code == m_cand) m_run++;
      else if (n == 1 && m_run == 0) begin m_cand = code; m_run = 1; end
      else m_run = 0;
      if (m_run == D) begin
        m_pulses++;
        m_code   = m_cand;
        m_digits = {m_digits[11:0], m_cand};
        m_held   = 1'b1;
        m_rel    = 0;
        m_run    = 0;
      end
    end else begin
      if (n == 0) m_rel++;
      else m_rel = 0;
      if (m_rel == D) begin m_held = 1'b0; m_rel = 0; end
    end
  endtask

  // Entered and left at #1 after a clk that is 13 mod 16 past reset release, so the
  // new key set is stable before column 0 of the next scan is sampled. The check in
  // the middle sees the complete effect of the previous scan.
  task automatic do_scan(input logic [15:0] m);
    pressed = m;
    repeat (3) @(posedge clk);
    #1;
    check_state();
    model_scan(m);
    repeat (13) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input int n);
    for (int i = 0; i < n; i++) do_scan(16'd1 << idx);
  endtask

  task automatic idle_scans(input int n);
    for (int i = 0; i < n; i++) do_scan(16'd0);
  endtask

  task automatic do_reset();
    pressed = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_col",   {12'd0, col}, 16'h000E);
    check("rst_valid", {15'd0, key_valid}, 16'd0);
    check("rst_held",  {15'd0, key_held}, 16'd0);
    check("rst_code",  {12'd0, key_code}, 16'd0);
    check("rst_digits", digits, 16'h0000);
    @(negedge clk) rst = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    m_run = 0; m_rel = 0; m_held = 1'b0; m_code = 4'h0; m_digits = 16'h0000;
  endtask

  initial begin
    logic [15:0] m;
    int kind, reps, a, b;

    do_reset();

    // '5' held past debounce, then released.
    press(5, 6);
    idle_scans(5);
    check("five_code", {12'd0, key_code}, 16'h0005);
    check("five_digits", digits, 16'h0005);

    // Bouncy '9'.
    press(10, 2);
    idle_scans(1);
    press(10, 4);
    idle_scans(5);

    // '1' and '2' together never qualify.
    for (int i = 0; i < 6; i++) do_scan(16'h0003);
    idle_scans(2);

    // Sequence 1,2,3,A fills the history.
    for (int k = 0; k < 4; k++) begin
      press(k, 4);
      idle_scans(4);
    end
    check("seq_digits", digits, 16'h123A);

    // Reset while debouncing '7', then a fresh debounce.
    press(8, 2);
    do_reset();
    check("rst_no_pulse", 16'(pulses), 16'(m_pulses));
    press(8, 3);
    press(8, 1);
    idle_scans(5);

    // Random runs of no key, single keys and key pairs.
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      reps = $urandom_range(1, 6);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      if (kind < 3)      m = 16'd0;
      else if (kind < 9) m = 16'd1 << a;
      else               m = (16'd1 << a) | (16'd1 << b);
      for (int i = 0; i < reps; i++) do_scan(m);
    end
    idle_scans(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
